// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity-framed serial transmitter.
package parity_frame_pkg;

  localparam int unsigned FRAME_BITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic calc_parity(input logic [3:0] nib, input logic odd);
    return (^nib) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while running, pulses o_bit_done on wrap.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_bit_done
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_bit_done = i_run && (r_cnt == LAST);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter: start bit, 4 data bits LSB first, parity bit, stop bit.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       parity_out
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_shift, w_shift_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_par, w_par_nxt;
  logic       r_tx, w_tx_nxt;
  logic       w_run;
  logic       w_bit_done;

  assign w_run = (r_state != IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_par_nxt   = r_par;
    case (r_state)
      IDLE: begin
        if (valid) begin
          w_state_nxt = START;
          w_shift_nxt = data_in;
          w_par_nxt   = calc_parity(data_in, PARITY_ODD);
          w_idx_nxt   = '0;
        end
      end
      START: begin
        if (w_bit_done) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = {1'b0, r_shift[3:1]};
          w_idx_nxt   = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (w_bit_done) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // tx is registered from the next-state view so each bit appears on the
    // first cycle of its slot without a combinational path to the pin.
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_par_nxt;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign ready      = (r_state == IDLE);
  assign busy       = ~ready;
  assign tx         = r_tx;
  assign parity_out = r_par;

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4; clock cycles each serial bit is held; legal range 1..255.
REQ-002 Parameter PARITY_ODD, default 0; 0 = even parity bit, 1 = odd parity bit.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 data_in  input  4  nibble to transmit, sampled only on acceptance.
REQ-006 valid  input  1  data_in holds a nibble to send.
REQ-007 ready  output  1  block can accept a nibble this cycle.
REQ-008 tx  output  1  serial line; idle high.
REQ-009 busy  output  1  frame in progress.
REQ-010 parity_out  output  1  parity bit of the last accepted nibble.

Function
REQ-011 The block SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-012 ready SHALL be 1 only in IDLE; busy SHALL equal NOT ready.
REQ-013 Acceptance SHALL occur on a rising edge with valid=1 and ready=1: latch data_in into the shift register, latch parity into parity_out, and enter START.
REQ-014 Parity SHALL be XOR of the four data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-015 tx SHALL be 1 in IDLE, 0 in START, data bit in DATA (LSB first, bits 0..3), parity_out in PARITY, and 1 in STOP.
REQ-016 START, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles; DATA SHALL last 4*CLKS_PER_BIT cycles.
REQ-017 A frame SHALL be 7*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-018 tx SHALL be driven from a register with no combinational path from data_in or valid.
REQ-019 The first START cycle SHALL be the cycle after acceptance.
REQ-020 After the last STOP cycle the block SHALL return to IDLE for at least one cycle before the next acceptance, so back-to-back frames are separated by exactly one idle-high cycle.
REQ-021 Changes on data_in or valid while busy=1 SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-022 valid deasserted in IDLE SHALL keep the block in IDLE indefinitely with tx=1.
REQ-023 The bit-time counter SHALL count 0..CLKS_PER_BIT-1 and wrap; with CLKS_PER_BIT=1 each bit SHALL last one cycle.
REQ-024 The data-bit index SHALL be 2 bits and advance only on the bit-time wrap.

Reset
REQ-025 While rst_n=0 at a rising edge, the block SHALL set state to IDLE, tx=1, ready=1, busy=0, parity_out=0, and clear the counters and shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the edge after rst_n is sampled low, and no partial frame SHALL resume.
REQ-027 The first acceptance SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-028 Package parity_frame_pkg SHALL hold the state enum and the constant FRAME_BITS=7.
REQ-029 Sub-module bit_timer SHALL hold the CLKS_PER_BIT counter and emit a one-cycle bit_done pulse on wrap; the FSM and shift register stay in parity_frame_tx.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 Reset, then valid=1 with data_in=4'b1010 for one cycle, PARITY_ODD=0 -> tx bit sequence 0,0,1,0,1,0,1, each held 4 cycles; parity_out=0; busy=1 for 28 cycles.
REQ-031 data_in=4'b0001 with PARITY_ODD=0 -> tx 0,1,0,0,0,1,1; parity_out=1.
REQ-032 data_in=4'b1011 with PARITY_ODD=1 -> parity_out=0; tx 0,1,1,0,1,0,1.
REQ-033 valid held high with data_in=4'b0000 then 4'b1111 -> two frames separated by exactly one tx=1 idle cycle; data_in changed mid-frame does not alter the frame.
REQ-034 rst_n pulled low during the DATA state -> tx=1, ready=1 the next edge; the next accepted nibble transmits a complete, correct frame.
REQ-035 CLKS_PER_BIT=1 with data_in=4'b0110 -> 7-cycle frame 0,0,1,1,0,0,1.
